// File: rtl/tl_pkg.sv
// Shared definitions for the traffic phase sequencer: phase codes, lamp
// encodings and the phase transition / duration helpers.
package tl_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LAMP_W  = 3;

    // Phase codes as presented on the phase output.
    typedef enum logic [PHASE_W-1:0] {
        PH_NS_GREEN  = 3'd0,
        PH_NS_YELLOW = 3'd1,
        PH_ALL_RED_A = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_ALL_RED_B = 3'd5,
        PH_PED_WALK  = 3'd6,
        PH_FLASH     = 3'd7
    } phase_t;

    // Lamp encodings, {red, yellow, green}.
    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

    // A zero duration would never expire; treat it as one tick.
    function automatic logic [CNT_W-1:0] clamp_dur(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    // Normal-cycle successor; anything unexpected restarts at NS green.
    function automatic phase_t next_phase(input phase_t p, input logic pend);
        case (p)
            PH_NS_GREEN:  return PH_NS_YELLOW;
            PH_NS_YELLOW: return PH_ALL_RED_A;
            PH_ALL_RED_A: return PH_EW_GREEN;
            PH_EW_GREEN:  return PH_EW_YELLOW;
            PH_EW_YELLOW: return PH_ALL_RED_B;
            PH_ALL_RED_B: return pend ? PH_PED_WALK : PH_NS_GREEN;
            default:      return PH_NS_GREEN;
        endcase
    endfunction

    // Tick count to load on entry to a phase; FLASH has no timed duration.
    function automatic logic [CNT_W-1:0] phase_duration(
        input phase_t           p,
        input logic [CNT_W-1:0] ns_green,
        input logic [CNT_W-1:0] ew_green,
        input logic [CNT_W-1:0] yellow,
        input logic [CNT_W-1:0] all_red,
        input logic [CNT_W-1:0] walk
    );
        case (p)
            PH_NS_GREEN:  return ns_green;
            PH_NS_YELLOW: return yellow;
            PH_ALL_RED_A: return all_red;
            PH_EW_GREEN:  return ew_green;
            PH_EW_YELLOW: return yellow;
            PH_ALL_RED_B: return all_red;
            PH_PED_WALK:  return walk;
            default:      return '0;
        endcase
    endfunction

    // North-South lamp pattern for a steady phase.
    function automatic logic [LAMP_W-1:0] lamp_ns(input phase_t p);
        case (p)
            PH_NS_GREEN:  return LAMP_GRN;
            PH_NS_YELLOW: return LAMP_YEL;
            PH_FLASH:     return LAMP_YEL;
            default:      return LAMP_RED;
        endcase
    endfunction

    // East-West lamp pattern for a steady phase.
    function automatic logic [LAMP_W-1:0] lamp_ew(input phase_t p);
        case (p)
            PH_EW_GREEN:  return LAMP_GRN;
            PH_EW_YELLOW: return LAMP_YEL;
            PH_FLASH:     return LAMP_YEL;
            default:      return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable 8-bit down-counter holding the ticks left in the current phase.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (loads RST_VAL)
//   tick          - count enable, one pulse per second
//   load/load_val - load a new duration (zero is clamped to one)
//   park          - force the count to zero (untimed phase)
//   count         - registered ticks remaining
//   expire_c      - combinational: final tick of the phase is happening now
module phase_counter
    import tl_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = 8'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             park,
    output logic [CNT_W-1:0] count,
    output logic             expire_c
);

    assign expire_c = tick && (count == CNT_W'(1));

    // Decrement stops at one; the owner reloads on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= clamp_dur(RST_VAL);
        end else if (park) begin
            count <= '0;
        end else if (load) begin
            count <= clamp_dur(load_val);
        end else if (tick && (count > CNT_W'(1))) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer driven by a 1 Hz tick enable, with a
// latched pedestrian request that inserts a walk phase after ALL_RED_B.
// Optional macro TRAFFIC_FLASH_MODE_EN adds flash_req and the flashing-yellow
// FLASH phase.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   tick_en    - one-cycle per-second advance enable
//   flash_req  - (TRAFFIC_FLASH_MODE_EN only) request flashing yellow
//   ped_req    - pedestrian button level, sampled every clk
//   ns_lights  - North-South lamps {red, yellow, green}
//   ew_lights  - East-West lamps {red, yellow, green}
//   ped_walk   - walk lamp
//   ped_ack    - one-cycle pulse on entry to the walk phase
//   phase      - current phase code
//   secs_left  - ticks remaining in the current phase
module traffic_phase_sequencer
    import tl_pkg::*;
#(
    parameter logic [CNT_W-1:0] NS_GREEN_S = 8'd20,
    parameter logic [CNT_W-1:0] EW_GREEN_S = 8'd15,
    parameter logic [CNT_W-1:0] YELLOW_S   = 8'd3,
    parameter logic [CNT_W-1:0] ALL_RED_S  = 8'd1,
    parameter logic [CNT_W-1:0] WALK_S     = 8'd10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_en,
`ifdef TRAFFIC_FLASH_MODE_EN
    input  logic               flash_req,
`endif
    input  logic               ped_req,
    output logic [LAMP_W-1:0]  ns_lights,
    output logic [LAMP_W-1:0]  ew_lights,
    output logic               ped_walk,
    output logic               ped_ack,
    output logic [PHASE_W-1:0] phase,
    output logic [CNT_W-1:0]   secs_left
);

    localparam logic [CNT_W-1:0] NS_G  = clamp_dur(NS_GREEN_S);
    localparam logic [CNT_W-1:0] EW_G  = clamp_dur(EW_GREEN_S);
    localparam logic [CNT_W-1:0] YEL   = clamp_dur(YELLOW_S);
    localparam logic [CNT_W-1:0] AR    = clamp_dur(ALL_RED_S);
    localparam logic [CNT_W-1:0] WALK  = clamp_dur(WALK_S);

    phase_t             phase_q;
    phase_t             phase_d;
    logic               ped_pending;
    logic               pend_d;
    logic               ack_d;
    logic               walk_d;
    logic [LAMP_W-1:0]  ns_d;
    logic [LAMP_W-1:0]  ew_d;
    logic               cnt_load;
    logic               cnt_park;
    logic [CNT_W-1:0]   cnt_val;
    logic               expire;

    assign phase = phase_q;

    // Ticks remaining; its register is the secs_left output.
    phase_counter #(
        .RST_VAL (NS_G)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick_en),
        .load     (cnt_load),
        .load_val (cnt_val),
        .park     (cnt_park),
        .count    (secs_left),
        .expire_c (expire)
    );

    // Phase, pending request and lamp registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_NS_GREEN;
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
            ped_walk    <= 1'b0;
            ns_lights   <= LAMP_GRN;
            ew_lights   <= LAMP_RED;
        end else begin
            phase_q     <= phase_d;
            ped_pending <= pend_d;
            ped_ack     <= ack_d;
            ped_walk    <= walk_d;
            ns_lights   <= ns_d;
            ew_lights   <= ew_d;
        end
    end

    // Next phase, counter control and next lamp pattern.
    always_comb begin
        phase_d  = phase_q;
        cnt_load = 1'b0;
        cnt_park = 1'b0;
        cnt_val  = '0;
        pend_d   = ped_pending | ped_req;
        ack_d    = 1'b0;
        ns_d     = ns_lights;
        ew_d     = ew_lights;
        walk_d   = 1'b0;

`ifdef TRAFFIC_FLASH_MODE_EN
        if (tick_en && flash_req) begin
            phase_d  = PH_FLASH;
            cnt_park = 1'b1;
        end else if (phase_q == PH_FLASH) begin
            // Leave flash through a clearance phase before resuming.
            if (tick_en) begin
                phase_d  = PH_ALL_RED_B;
                cnt_load = 1'b1;
                cnt_val  = AR;
            end
        end else if (expire) begin
            phase_d  = next_phase(phase_q, ped_pending);
            cnt_load = 1'b1;
            cnt_val  = phase_duration(phase_d, NS_G, EW_G, YEL, AR, WALK);
        end
`else
        if (phase_q == PH_FLASH) begin
            // Unreachable code without flash support: recover immediately.
            phase_d  = PH_NS_GREEN;
            cnt_load = 1'b1;
            cnt_val  = NS_G;
        end else if (expire) begin
            phase_d  = next_phase(phase_q, ped_pending);
            cnt_load = 1'b1;
            cnt_val  = phase_duration(phase_d, NS_G, EW_G, YEL, AR, WALK);
        end
`endif

        // Entering walk serves the request; a same-cycle press is absorbed.
        if ((phase_d == PH_PED_WALK) && (phase_q != PH_PED_WALK)) begin
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        ns_d   = lamp_ns(phase_d);
        ew_d   = lamp_ew(phase_d);
        walk_d = (phase_d == PH_PED_WALK);

`ifdef TRAFFIC_FLASH_MODE_EN
        // Entry shows yellow; each further tick in flash toggles it.
        if ((phase_d == PH_FLASH) && (phase_q == PH_FLASH)) begin
            ns_d = tick_en ? (ns_lights ^ LAMP_YEL) : ns_lights;
            ew_d = tick_en ? (ew_lights ^ LAMP_YEL) : ew_lights;
        end
`endif
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Randomized self-checking bench for traffic_phase_sequencer against a
// tick-level behavioural model of the intersection.
module tb_traffic_phase_sequencer;

    localparam logic [7:0] P_NS   = 8'd3;
    localparam logic [7:0] P_EW   = 8'd2;
    localparam logic [7:0] P_YEL  = 8'd2;
    localparam logic [7:0] P_AR   = 8'd1;
    localparam logic [7:0] P_WALK = 8'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_en;
    logic       ped_req;
`ifdef TRAFFIC_FLASH_MODE_EN
    logic       flash_req;
`endif
    logic [2:0] ns_lights;
    logic [2:0] ew_lights;
    logic       ped_walk;
    logic       ped_ack;
    logic [2:0] phase;
    logic [7:0] secs_left;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: phase number, ticks left, pending request, ack, flash lamp.
    int m_ph;
    int m_left;
    bit m_pend;
    bit m_ack;
    bit m_yel;

    int dur[8] = '{int'(P_NS), int'(P_YEL), int'(P_AR), int'(P_EW),
                   int'(P_YEL), int'(P_AR), int'(P_WALK), 0};
    logic [2:0] ns_tab[8] = '{3'b001, 3'b010, 3'b100, 3'b100,
                              3'b100, 3'b100, 3'b100, 3'b010};
    logic [2:0] ew_tab[8] = '{3'b100, 3'b100, 3'b100, 3'b001,
                              3'b010, 3'b100, 3'b100, 3'b010};
    int exp_seq[6] = '{1, 2, 3, 4, 5, 0};
    int exp_dw[6]  = '{3, 2, 1, 2, 2, 1};

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .NS_GREEN_S (P_NS),
        .EW_GREEN_S (P_EW),
        .YELLOW_S   (P_YEL),
        .ALL_RED_S  (P_AR),
        .WALK_S     (P_WALK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_en   (tick_en),
`ifdef TRAFFIC_FLASH_MODE_EN
        .flash_req (flash_req),
`endif
        .ped_req   (ped_req),
        .ns_lights (ns_lights),
        .ew_lights (ew_lights),
        .ped_walk  (ped_walk),
        .ped_ack   (ped_ack),
        .phase     (phase),
        .secs_left (secs_left)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one clk edge with the inputs that were applied.
    task automatic model_step(input bit r, input bit t, input bit p, input bit f);
        bit np;
        if (r) begin
            m_ph = 0; m_left = dur[0]; m_pend = 0; m_ack = 0; m_yel = 0;
            return;
        end
        m_ack = 0;
        np = m_pend | p;
        if (f && t) begin
            m_yel  = (m_ph != 7) ? 1'b1 : !m_yel;
            m_ph   = 7;
            m_left = 0;
        end else if (m_ph == 7) begin
            if (t) begin
                m_ph = 5; m_left = dur[5];
            end
        end else if (t) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                int nx;
                if (m_ph == 5)      nx = m_pend ? 6 : 0;
                else if (m_ph == 6) nx = 0;
                else                nx = m_ph + 1;
                if (nx == 6) begin
                    np = 0; m_ack = 1;
                end
                m_ph = nx; m_left = dur[nx];
            end
        end
        m_pend = np;
    endtask

    task automatic check_all();
        logic [2:0] ens, eew;
        ens = (m_ph == 7) ? (m_yel ? 3'b010 : 3'b000) : ns_tab[m_ph];
        eew = (m_ph == 7) ? (m_yel ? 3'b010 : 3'b000) : ew_tab[m_ph];
        check("phase",     32'(phase),     32'(m_ph));
        check("secs_left", 32'(secs_left), 32'(m_left));
        check("ns_lights", 32'(ns_lights), 32'(ens));
        check("ew_lights", 32'(ew_lights), 32'(eew));
        check("ped_walk",  32'(ped_walk),  32'(m_ph == 6));
        check("ped_ack",   32'(ped_ack),   32'(m_ack));
    endtask

    function automatic bit tick_now();
        return (cyc % 5) == 4;
    endfunction

    // One clock: drive, let the edge pass, update model, compare.
    task automatic cycle(input bit r, input bit t, input bit p, input bit f);
        rst     = r;
        tick_en = t;
        ped_req = p;
`ifdef TRAFFIC_FLASH_MODE_EN
        flash_req = f;
`endif
        @(posedge clk);
        model_step(r, t, p, f);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic run_until(input int target, input int maxc, input bit p, input bit f, input string tag);
        int n = 0;
        while (int'(phase) != target && n < maxc) begin
            cycle(0, tick_now(), p, f);
            n++;
        end
        check(tag, 32'(phase), 32'(target));
    endtask

    task automatic run_until_not(input int target, input int maxc, input bit p, input bit f, input string tag);
        int n = 0;
        while (int'(phase) == target && n < maxc) begin
            cycle(0, tick_now(), p, f);
            n++;
        end
        check(tag, 32'(int'(phase) != target), 32'd1);
    endtask

    // Clock until one tick has been applied.
    task automatic tick_cycle(input bit p, input bit f);
        bit done = 0;
        for (int n = 0; n < 6 && !done; n++) begin
            done = tick_now();
            cycle(0, done, p, f);
        end
    endtask

    initial begin
        int seq[$];
        int dw[$];
        int tk, walks, acks, wcyc, prev;
        bit seen6, t, flash_lvl;
        logic [2:0] saved_ph;
        logic [7:0] saved_secs;

        rst = 1'b1; tick_en = 1'b0; ped_req = 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
        flash_req = 1'b0;
`endif
        m_ph = 0; m_left = dur[0]; m_pend = 0; m_ack = 0; m_yel = 0;

        // Reset state, then one undisturbed cycle of phases.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_secs",  32'(secs_left), 32'(P_NS));
        check("rst_ns",    32'(ns_lights), 32'b001);
        check("rst_ew",    32'(ew_lights), 32'b100);
        prev = int'(phase); tk = 0; walks = 0;
        for (int i = 0; i < 100 && seq.size() < 6; i++) begin
            t = tick_now();
            cycle(0, t, 0, 0);
            if (t) tk++;
            if (phase == 3'd6) walks++;
            if (int'(phase) != prev) begin
                seq.push_back(int'(phase)); dw.push_back(tk);
                tk = 0; prev = int'(phase);
            end
        end
        check("seq_len", 32'(seq.size()), 32'd6);
        for (int k = 0; k < 6 && k < seq.size(); k++) begin
            check("seq_phase", 32'(seq[k]), 32'(exp_seq[k]));
            check("seq_dwell", 32'(dw[k]),  32'(exp_dw[k]));
        end
        check("no_walk", 32'(walks), 32'd0);

        // Single-cycle press during EW green is served after ALL_RED_B.
        run_until(3, 200, 0, 0, "reach_ew_green");
        cycle(0, tick_now(), 1, 0);
        acks = 0; wcyc = 0; seen6 = 0;
        for (int i = 0; i < 300 && !(seen6 && phase == 3'd0); i++) begin
            cycle(0, tick_now(), 0, 0);
            if (ped_ack) acks++;
            if (ped_walk) wcyc++;
            if (phase == 3'd6) seen6 = 1;
        end
        check("walk_seen",   32'(seen6), 32'd1);
        check("ack_pulses",  32'(acks),  32'd1);
        check("walk_cycles", 32'(wcyc),  32'(5 * int'(P_WALK)));
        check("after_walk",  32'(phase), 32'd0);

        // Press held through the walk entry edge is absorbed, not re-latched.
        run_until(4, 200, 0, 0, "reach_ew_yellow");
        run_until(6, 200, 1, 0, "held_walk");
        run_until(0, 200, 0, 0, "walk_done");
        run_until(5, 200, 0, 0, "reach_all_red_b");
        run_until_not(5, 50, 0, 0, "leave_all_red_b");
        check("absorbed_skip", 32'(phase), 32'd0);

        // Reset with coincident tick and press during EW yellow.
        run_until(4, 200, 0, 0, "reach_ew_yellow2");
        cycle(1, 1, 1, 0);
        check("midrst_phase", 32'(phase),     32'd0);
        check("midrst_secs",  32'(secs_left), 32'(P_NS));
        check("midrst_ns",    32'(ns_lights), 32'b001);
        check("midrst_ew",    32'(ew_lights), 32'b100);

        // No ticks: everything holds, then one tick decrements by one.
        saved_ph = phase; saved_secs = secs_left;
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 0, 0);
            check("hold_phase", 32'(phase),     32'(saved_ph));
            check("hold_secs",  32'(secs_left), 32'(saved_secs));
        end
        cycle(0, 1, 0, 0);
        check("one_tick", 32'(secs_left), 32'(saved_secs - 8'd1));

        // The dropped request must not produce a walk.
        run_until(5, 200, 0, 0, "reach_all_red_b2");
        run_until_not(5, 50, 0, 0, "leave_all_red_b2");
        check("rst_drops_req", 32'(phase), 32'd0);

        // Random presses, irregular ticks, rare resets (and flash bursts).
        flash_lvl = 0;
        for (int i = 0; i < 1500; i++) begin
`ifdef TRAFFIC_FLASH_MODE_EN
            if ($urandom_range(0, 59) == 0) flash_lvl = !flash_lvl;
`endif
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0, flash_lvl);
        end

`ifdef TRAFFIC_FLASH_MODE_EN
        // Flash from NS green: yellow alternates per tick, exit via ALL_RED_B.
        run_until(0, 300, 0, 0, "reach_ns_green");
        for (int k = 0; k < 4; k++) begin
            tick_cycle(0, 1);
            check("flash_phase", 32'(phase),     32'd7);
            check("flash_secs",  32'(secs_left), 32'd0);
            check("flash_ns",    32'(ns_lights), (k % 2 == 0) ? 32'b010 : 32'b000);
            check("flash_ew",    32'(ew_lights), (k % 2 == 0) ? 32'b010 : 32'b000);
        end
        tick_cycle(0, 0);
        check("flash_exit_phase", 32'(phase),     32'd5);
        check("flash_exit_secs",  32'(secs_left), 32'(P_AR));
        tick_cycle(0, 0);
        check("flash_resume", 32'(phase), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
